// File: rtl/vl_pkg.sv
// Shared definitions for the vector loader: default geometry, the lane word
// type and the gather FSM state encoding.
package vl_pkg;

  localparam int LANES_DEF  = 16;
  localparam int STRIDE_DEF = 4;

  typedef logic [31:0] lane_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

endpackage

// File: rtl/vector_loader_if.sv
// Memory read port of the vector loader. The loader is the master and issues
// read strobes and addresses. The memory is the slave and returns data one
// cycle after each strobe.
interface vector_loader_if;
  import vl_pkg::*;

  logic  mem_re;
  lane_t mem_addr;
  lane_t mem_rdata;

  modport master (output mem_re, output mem_addr, input mem_rdata);
  modport slave  (input mem_re, input mem_addr, output mem_rdata);

endinterface

// File: rtl/signmag_conv.sv
// Two's complement to 16-bit sign-magnitude converter for one lane word.
// Bit 15 holds the sign. Bits 14:0 hold |v| saturated to 32767.
// Bits 31:16 are zero. Zero maps to +0. Only instantiated when
// VL_SIGNMAG_CONV_EN is defined.
module signmag_conv
  import vl_pkg::*;
(
  input  lane_t data_i,
  output lane_t data_o
);

  localparam lane_t MAG_MAX = 32'd32767;

  logic  neg;
  lane_t mag;

  // Magnitude by negation. 0x80000000 negates to itself, read as the unsigned
  // value 2^31, so it saturates like any other large value.
  always_comb begin
    neg         = data_i[31];
    mag         = neg ? (~data_i + 32'd1) : data_i;
    data_o      = '0;
    data_o[15]  = neg;
    data_o[14:0] = (mag > MAG_MAX) ? 15'h7FFF : mag[14:0];
  end

endmodule

// File: rtl/vector_loader.sv
// Vector loader: gathers LANES 32-bit words from base_addr + STRIDE*i over a
// single-port read interface. The result is presented as one wide vector with
// a valid/ready handshake.
// Optional feature macro: VL_SIGNMAG_CONV_EN. When defined, each captured
// word is converted to sign-magnitude before it is stored in its lane.
module vector_loader
  import vl_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int STRIDE = STRIDE_DEF
)
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  lane_t                  base_addr,
  vector_loader_if.master        mem,
  output lane_t [LANES-1:0]      rd,
  output logic                   vec_valid,
  input  logic                   vec_ready,
  output logic                   busy
);

  localparam int          CW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  lane_t            base_q, base_d;
  logic             cap_vld_q;
  logic [CW-1:0]    cap_idx_q;
  lane_t [LANES-1:0] rd_q;
  lane_t            cap_word;

  // Next-state logic: accept start in IDLE, or in HOLD on the handshake cycle.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
          base_d  = base_addr;
        end
      end
      FETCH: begin
        if (cnt_q == LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: state_d = HOLD;
      HOLD: begin
        if (vec_ready) begin
          if (start) begin
            state_d = FETCH;
            cnt_d   = '0;
            base_d  = base_addr;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, lane counter and captured base address registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
    end
  end

  // Read issue. The address wraps modulo 2^32 naturally in 32-bit arithmetic.
  assign mem.mem_re   = (state_q == FETCH);
  assign mem.mem_addr = base_q + lane_t'(STRIDE) * lane_t'(cnt_q);

  // Remember which lane the read issued in this cycle belongs to. Data for
  // that lane arrives in the following cycle. Reset drops any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      cap_vld_q <= mem.mem_re;
      cap_idx_q <= cnt_q;
    end
  end

`ifdef VL_SIGNMAG_CONV_EN
  signmag_conv u_conv (
    .data_i (mem.mem_rdata),
    .data_o (cap_word)
  );
`else
  assign cap_word = mem.mem_rdata;
`endif

  // Lane storage. Only the lane whose read returned this cycle is written.
  // NOTE: the lane array is reset because it drives an output that must read
  // zero while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (cap_vld_q) begin
      rd_q[cap_idx_q] <= cap_word;
    end
  end

  assign rd        = rd_q;
  assign vec_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_loader.sv
// Self-checking bench for vector_loader. A scoreboard queues the expected read
// addresses and the expected vectors when each start is driven. It pops them
// as the DUT issues reads and as vectors are handed off.
module tb_vector_loader;
  import vl_pkg::*;

  localparam int LANES  = 16;
  localparam int STRIDE = 4;

  typedef logic [LANES-1:0][31:0] vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  lane_t            base_addr;
  lane_t [LANES-1:0] rd;
  logic             vec_valid;
  logic             vec_ready;
  logic             busy;

  vector_loader_if mem_if ();

  vector_loader #(.LANES(LANES), .STRIDE(STRIDE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .mem       (mem_if),
    .rd        (rd),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   issues   = 0;
  lane_t addr_q[$];
  vec_t  vec_q[$];

  // Memory contents. Addresses in the 0x300 window hold the conversion
  // corner cases. Everywhere else word[a] = a.
  function automatic lane_t mem_f(lane_t a);
    case (a)
      32'h0000_0300: return 32'hFFFF_FFFB;  // -5
      32'h0000_0304: return 32'd40000;
      32'h0000_0308: return 32'h0000_0000;
      32'h0000_030C: return 32'h8000_0000;
      default:       return a;
    endcase
  endfunction

  // Expected lane content for a memory word.
  function automatic lane_t exp_word(lane_t w);
`ifdef VL_SIGNMAG_CONV_EN
    longint v;
    longint m;
    logic   s;
    v = longint'($signed(w));
    s = (v < 0);
    m = s ? -v : v;
    if (m > 32767) m = 32767;
    return {16'h0000, s, m[14:0]};
`else
    return w;
`endif
  endfunction

  // Memory model: returns data one cycle after each read strobe.
  // Outside a strobe it returns a poison word, which exposes stray captures.
  always @(posedge clk)
    mem_if.mem_rdata <= mem_if.mem_re ? mem_f(mem_if.mem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and score any read issued in that cycle.
  task automatic step();
    lane_t exp_a;
    @(negedge clk);
    if (mem_if.mem_re === 1'b1) begin
      issues++;
      if (addr_q.size() == 0) begin
        check("spurious_mem_re", 32'd1, 32'd0);
      end else begin
        exp_a = addr_q.pop_front();
        check("mem_addr", mem_if.mem_addr, exp_a);
      end
    end
  endtask

  // Drive a start and push its expected address sequence and vector.
  task automatic begin_vec(input lane_t base);
    vec_t  v;
    lane_t a;
    for (int i = 0; i < LANES; i++) begin
      a = base + lane_t'(STRIDE * i);
      addr_q.push_back(a);
      v[i] = exp_word(mem_f(a));
    end
    vec_q.push_back(v);
    start     = 1'b1;
    base_addr = base;
  endtask

  // Cross the accept edge.
  task automatic accept();
    issues = 0;
    step();
    start     = 1'b0;
    vec_ready = 1'b0;
  endtask

  // Wait for vec_valid, optionally pulsing start throughout the gather.
  task automatic wait_valid(input bit pulse);
    int cyc = 0;
    while (vec_valid !== 1'b1 && cyc < 40) begin
      if (pulse) begin
        start     = (cyc % 3 == 0);
        base_addr = 32'hBAD0_0000;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("valid_latency", cyc, LANES + 1);
    check("issue_count", issues, LANES);
    check("addr_q_drained", addr_q.size(), 0);
  endtask

  // Hold with vec_ready low for n cycles. The vector must stay put.
  task automatic check_hold(input int n);
    vec_t e;
    if (vec_q.size() == 0) begin
      check("vec_q_nonempty", 32'd0, 32'd1);
      return;
    end
    e = vec_q[0];
    vec_ready = 1'b0;
    for (int k = 0; k < n; k++) begin
      check("hold_valid", vec_valid, 1'b1);
      check("hold_busy", busy, 1'b1);
      for (int i = 0; i < LANES; i++) check($sformatf("rd[%0d]", i), rd[i], e[i]);
      step();
    end
  endtask

  // Handshake without a new start: the loader must be idle in the next cycle.
  task automatic handshake_idle();
    vec_ready = 1'b1;
    start     = 1'b0;
    void'(vec_q.pop_front());
    step();
    vec_ready = 1'b0;
    check("idle_busy", busy, 1'b0);
    check("idle_valid", vec_valid, 1'b0);
    check("idle_re", mem_if.mem_re, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_ready = 1'b0;
    base_addr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_re", mem_if.mem_re, 1'b0);
    check("rst_addr", mem_if.mem_addr, 32'h0);
    check("rst_valid", vec_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < LANES; i++) check($sformatf("rst_rd[%0d]", i), rd[i], 32'h0);
    rst_n = 1'b1;
    step();
    step();

    // Basic gather from 0x100, then a long stall in HOLD, then release.
    begin_vec(32'h0000_0100);
    accept();
    wait_valid(1'b0);
    check_hold(10);
    handshake_idle();
    step();

    // Start pulses during FETCH must not restart the gather.
    begin_vec(32'h0000_0180);
    accept();
    wait_valid(1'b1);
    check_hold(1);

    // Back-to-back: handshake and start in the same cycle.
    vec_ready = 1'b1;
    void'(vec_q.pop_front());
    begin_vec(32'h0000_0200);
    accept();
    check("b2b_re", mem_if.mem_re, 1'b1);
    check("b2b_addr", mem_if.mem_addr, 32'h0000_0200);
    wait_valid(1'b0);
    check_hold(1);
    handshake_idle();

    // Reset asserted while issue 7 is on the bus.
    begin_vec(32'h0000_0400);
    accept();
    repeat (7) step();
    check("pre_rst_addr", mem_if.mem_addr, 32'h0000_041C);
    rst_n = 1'b0;
    #1;
    check("mid_rst_re", mem_if.mem_re, 1'b0);
    check("mid_rst_addr", mem_if.mem_addr, 32'h0);
    check("mid_rst_valid", vec_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < LANES; i++) check($sformatf("mid_rst_rd[%0d]", i), rd[i], 32'h0);
    addr_q.delete();
    vec_q.delete();
    step();
    step();
    rst_n = 1'b1;
    repeat (5) step();
    check("post_rst_busy", busy, 1'b0);
    for (int i = 0; i < LANES; i++) check($sformatf("post_rst_rd[%0d]", i), rd[i], 32'h0);

    // Address wrap modulo 2^32.
    begin_vec(32'hFFFF_FFF8);
    accept();
    wait_valid(1'b0);
    check_hold(1);
    handshake_idle();

    // Conversion corner cases (a plain copy when conversion is disabled).
    begin_vec(32'h0000_0300);
    accept();
    wait_valid(1'b0);
    check_hold(2);
    handshake_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_loader.md
VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter LANES, default 16, number of 32-bit lanes gathered per vector.
REQ-002 SHALL have parameter STRIDE, default 4, byte distance between consecutive lane addresses.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request to gather one vector; sampled only when accepted per REQ-012.
REQ-006 SHALL have port base_addr  input  32  byte address of lane 0, captured when start is accepted.
REQ-007 SHALL have port mem_re  output  1  memory read strobe.
REQ-008 SHALL have port mem_addr  output  32  memory read address, meaningful while mem_re=1.
REQ-009 SHALL have port mem_rdata  input  32  read data, valid exactly one cycle after the matching mem_re cycle.
REQ-010 SHALL have port rd  output  LANES x 32  gathered vector, lane i = word at base_addr + STRIDE*i.
REQ-011 SHALL have ports vec_valid output 1 / vec_ready input 1 (vector handshake) and busy output 1 (state != IDLE).

Function
REQ-012 SHALL implement FSM states IDLE, FETCH, DRAIN, HOLD; start is accepted in IDLE, or in HOLD on the handshake cycle.
REQ-013 SHALL, on accepted start, enter FETCH and assert mem_re for exactly LANES consecutive cycles, with mem_addr = base + STRIDE*i in issue cycle i (i = 0..LANES-1).
REQ-014 SHALL compute addresses modulo 2^32; for example, base 0xFFFFFFF8 gives lane 2 at 0x00000000.
REQ-015 SHALL capture mem_rdata into lane i at the rising edge one cycle after issue i; no lane is written otherwise.
REQ-016 SHALL enter DRAIN after the last issue, capture lane LANES-1, then enter HOLD; vec_valid rises LANES+1 edges after the start-accept edge (17 for LANES=16).
REQ-017 SHALL hold vec_valid=1 and rd stable in HOLD until the vec_valid and vec_ready cycle.
REQ-018 SHALL, on the handshake, go to IDLE; if start=1 in that same cycle, it SHALL go directly to FETCH with the new base_addr (back-to-back, no bubble).
REQ-019 SHALL ignore start in FETCH and DRAIN, and ignore vec_ready outside HOLD.
REQ-020 SHALL keep mem_re=0 in IDLE, DRAIN and HOLD.

Reset
REQ-021 SHALL, while rst_n=0, force state IDLE, mem_re=0, mem_addr=0, all rd lanes=0, vec_valid=0, busy=0, lane counter 0.
REQ-022 SHALL, on reset assertion mid-FETCH, abandon the gather immediately; data returning after release SHALL NOT be captured.

Configuration
REQ-023 SHALL honour macro VL_SIGNMAG_CONV_EN; when defined, each captured word is converted from two's complement to 16-bit sign-magnitude: bit15 = sign, bits14:0 = |v| saturated to 32767, bits31:16 = 0.
REQ-024 SHALL, under VL_SIGNMAG_CONV_EN, map zero to 0x00000000 (never negative zero), and map 0x80000000 to 0x0000FFFF.
REQ-025 SHALL, without VL_SIGNMAG_CONV_EN, store mem_rdata into lanes unmodified.

Structure
REQ-026 SHALL take LANES default, the lane word typedef, and the FSM state enum from shared package vl_pkg.
REQ-027 SHALL place the per-word conversion in sub-module signmag_conv (32-bit in, 32-bit out, combinational), instantiated only under VL_SIGNMAG_CONV_EN.

Verification
REQ-028 SHALL cover: start, base 0x100, memory word[a] = a -> mem_addr 0x100..0x13C on 16 consecutive cycles, vec_valid at edge 17, rd[i] = 0x100+4i.
REQ-029 SHALL cover: vec_ready=0 for 10 cycles in HOLD -> rd and vec_valid stable; vec_ready=1 -> IDLE next cycle, busy=0.
REQ-030 SHALL cover: handshake cycle with start=1 and base 0x200 -> mem_re in the very next cycle with mem_addr 0x200.
REQ-031 SHALL cover: start pulses during FETCH -> no restart, address sequence unchanged.
REQ-032 SHALL cover: rst_n low at issue 7 -> outputs zero immediately; after release no lane is written until a new start.
REQ-033 SHALL cover, with VL_SIGNMAG_CONV_EN: words -5, 40000, 0, 0x80000000 -> lanes 0x8005, 0x7FFF, 0x0000, 0xFFFF.
